// File: rtl/spell_pkg.sv
// Shared types and constants for the spell RAM-bus arbiter.
package spell_pkg;

    localparam int RAM_ADDR_W = 10;

    // State encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_GRANT0 = 2'b01,
        ST_GRANT1 = 2'b10
    } arb_state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

endpackage

// File: rtl/spell_bus_watchdog.sv
// Counts strobe-without-ack cycles; expired holds while the count sits at TIMEOUT.
module spell_bus_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] r_count;

    // Saturates at LIMIT so a stalled owner cannot wrap back into silence.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count != LIMIT)) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign expired = (TIMEOUT != 0) && (r_count == LIMIT);

endmodule

// File: rtl/spell_rambus_arbiter.sv
// Round-robin, cyc-locked arbiter sharing the OpenRAM Wishbone port between
// the spell core (master 0) and the host loader (master 1), with abort watchdog.
module spell_rambus_arbiter
    import spell_pkg::*;
#(
    parameter int ADDR_W  = RAM_ADDR_W,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [3:0]        m0_sel_i,
    input  logic [31:0]       m0_dat_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    output logic [31:0]       m0_dat_o,
    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [3:0]        m1_sel_i,
    input  logic [31:0]       m1_dat_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic [31:0]       m1_dat_o,
    output logic              ram_cyc_o,
    output logic              ram_stb_o,
    output logic              ram_we_o,
    output logic [3:0]        ram_sel_o,
    output logic [31:0]       ram_dat_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    input  logic              ram_ack_i,
    input  logic [31:0]       ram_dat_i,
    output logic [1:0]        grant_o,
    output logic              timeout_flag_o,
    input  logic              timeout_clr_i
);

    arb_state_t r_state;
    arb_state_t w_next_state;
    logic       r_last_grant;   // 1: master 1 held the bus last
    logic [1:0] r_blocked;      // aborted master waits here until it drops cyc
    logic       r_timeout_flag;
    logic [1:0] w_req;
    logic       w_own_cyc;
    logic       w_own_stb;
    logic       w_expired;
    logic       w_abort;
    logic       w_wd_clear;
    logic       w_wd_enable;

    assign w_req     = {m1_cyc_i & ~r_blocked[1], m0_cyc_i & ~r_blocked[0]};
    assign w_own_cyc = (r_state == ST_GRANT0) ? m0_cyc_i :
                       (r_state == ST_GRANT1) ? m1_cyc_i : 1'b0;
    assign w_own_stb = (r_state == ST_GRANT0) ? m0_stb_i :
                       (r_state == ST_GRANT1) ? m1_stb_i : 1'b0;

    assign w_abort     = w_own_stb & w_expired;
    assign w_wd_clear  = (r_state == ST_IDLE) | ~w_own_stb | ram_ack_i;
    assign w_wd_enable = w_own_stb & ~ram_ack_i;

    spell_bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (w_wd_clear),
        .enable  (w_wd_enable),
        .expired (w_expired)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_req == 2'b11) begin
                    w_next_state = r_last_grant ? ST_GRANT0 : ST_GRANT1;
                end else if (w_req[0]) begin
                    w_next_state = ST_GRANT0;
                end else if (w_req[1]) begin
                    w_next_state = ST_GRANT1;
                end
            end
            ST_GRANT0, ST_GRANT1: begin
                if (w_abort || !w_own_cyc) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        ram_cyc_o  = 1'b0;
        ram_stb_o  = 1'b0;
        ram_we_o   = 1'b0;
        ram_sel_o  = '0;
        ram_dat_o  = '0;
        ram_addr_o = '0;
        m0_ack_o   = 1'b0;
        m1_ack_o   = 1'b0;
        m0_err_o   = 1'b0;
        m1_err_o   = 1'b0;
        case (r_state)
            ST_GRANT0: begin
                ram_cyc_o  = ~w_abort;
                ram_stb_o  = m0_stb_i & ~w_abort;
                ram_we_o   = m0_we_i;
                ram_sel_o  = m0_sel_i;
                ram_dat_o  = m0_dat_i;
                ram_addr_o = m0_addr_i;
                m0_ack_o   = ram_ack_i & ~w_abort;
                m0_err_o   = w_abort;
            end
            ST_GRANT1: begin
                ram_cyc_o  = ~w_abort;
                ram_stb_o  = m1_stb_i & ~w_abort;
                ram_we_o   = m1_we_i;
                ram_sel_o  = m1_sel_i;
                ram_dat_o  = m1_dat_i;
                ram_addr_o = m1_addr_i;
                m1_ack_o   = ram_ack_i & ~w_abort;
                m1_err_o   = w_abort;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last_grant   <= 1'b1;
            r_blocked      <= 2'b00;
            r_timeout_flag <= 1'b0;
        end else begin
            if ((r_state != ST_IDLE) && (w_next_state == ST_IDLE)) begin
                r_last_grant <= (r_state == ST_GRANT1);
            end
            r_blocked[0] <= (w_abort && (r_state == ST_GRANT0)) | (r_blocked[0] & m0_cyc_i);
            r_blocked[1] <= (w_abort && (r_state == ST_GRANT1)) | (r_blocked[1] & m1_cyc_i);
            if (w_abort) begin
                r_timeout_flag <= 1'b1;
            end else if (timeout_clr_i) begin
                r_timeout_flag <= 1'b0;
            end
        end
    end

    assign grant_o        = r_state;
    assign timeout_flag_o = r_timeout_flag;
    assign m0_dat_o       = ram_dat_i;
    assign m1_dat_o       = ram_dat_i;

endmodule

// File: tb/tb_spell_rambus_arbiter.sv
// Directed bench for spell_rambus_arbiter: grant, handover, lock, timeout, async reset.
module tb_spell_rambus_arbiter;

    localparam int ADDR_W  = 10;
    localparam int TIMEOUT = 8;

    logic              clock = 1'b0;
    logic              reset;
    logic              m0_cyc_i, m0_stb_i, m0_we_i;
    logic [3:0]        m0_sel_i;
    logic [31:0]       m0_dat_i;
    logic [ADDR_W-1:0] m0_addr_i;
    logic              m0_ack_o, m0_err_o;
    logic [31:0]       m0_dat_o;
    logic              m1_cyc_i, m1_stb_i, m1_we_i;
    logic [3:0]        m1_sel_i;
    logic [31:0]       m1_dat_i;
    logic [ADDR_W-1:0] m1_addr_i;
    logic              m1_ack_o, m1_err_o;
    logic [31:0]       m1_dat_o;
    logic              ram_cyc_o, ram_stb_o, ram_we_o;
    logic [3:0]        ram_sel_o;
    logic [31:0]       ram_dat_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic              ram_ack_i;
    logic [31:0]       ram_dat_i;
    logic [1:0]        grant_o;
    logic              timeout_flag_o;
    logic              timeout_clr_i;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    spell_rambus_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clock          (clock),
        .reset          (reset),
        .m0_cyc_i       (m0_cyc_i),
        .m0_stb_i       (m0_stb_i),
        .m0_we_i        (m0_we_i),
        .m0_sel_i       (m0_sel_i),
        .m0_dat_i       (m0_dat_i),
        .m0_addr_i      (m0_addr_i),
        .m0_ack_o       (m0_ack_o),
        .m0_err_o       (m0_err_o),
        .m0_dat_o       (m0_dat_o),
        .m1_cyc_i       (m1_cyc_i),
        .m1_stb_i       (m1_stb_i),
        .m1_we_i        (m1_we_i),
        .m1_sel_i       (m1_sel_i),
        .m1_dat_i       (m1_dat_i),
        .m1_addr_i      (m1_addr_i),
        .m1_ack_o       (m1_ack_o),
        .m1_err_o       (m1_err_o),
        .m1_dat_o       (m1_dat_o),
        .ram_cyc_o      (ram_cyc_o),
        .ram_stb_o      (ram_stb_o),
        .ram_we_o       (ram_we_o),
        .ram_sel_o      (ram_sel_o),
        .ram_dat_o      (ram_dat_o),
        .ram_addr_o     (ram_addr_o),
        .ram_ack_i      (ram_ack_i),
        .ram_dat_i      (ram_dat_i),
        .grant_o        (grant_o),
        .timeout_flag_o (timeout_flag_o),
        .timeout_clr_i  (timeout_clr_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_sel_i = 4'h0; m0_dat_i = 0; m0_addr_i = 0;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_sel_i = 4'h0; m1_dat_i = 0; m1_addr_i = 0;
        ram_ack_i = 0; ram_dat_i = 0; timeout_clr_i = 0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        #12;
        check("rst_grant", 32'(grant_o), 32'h0);
        check("rst_ram_cyc", 32'(ram_cyc_o), 32'h0);
        check("rst_flag", 32'(timeout_flag_o), 32'h0);
        check("rst_m0_ack", 32'(m0_ack_o), 32'h0);
        reset = 1'b0;
        step();

        // single master read, ack next cycle
        m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 10'h012; m0_sel_i = 4'hF;
        #1;
        check("t1_req_cyc", 32'(ram_cyc_o), 32'h0);
        step();
        check("t1_ram_cyc", 32'(ram_cyc_o), 32'h1);
        check("t1_grant", 32'(grant_o), 32'h1);
        check("t1_addr", 32'(ram_addr_o), 32'h012);
        ram_ack_i = 1; ram_dat_i = 32'hDEADBEEF;
        #1;
        check("t1_m0_ack", 32'(m0_ack_o), 32'h1);
        check("t1_m0_dat", m0_dat_o, 32'hDEADBEEF);
        check("t1_m1_ack", 32'(m1_ack_o), 32'h0);
        step();
        ram_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        step();
        check("t1_release", 32'(grant_o), 32'h0);

        // simultaneous requests after reset
        pulse_reset();
        idle_inputs();
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        #1;
        check("t2_idle", 32'(grant_o), 32'h0);
        step();
        check("t2_first_m0", 32'(grant_o), 32'h1);
        ram_ack_i = 1;
        #1;
        check("t2_m0_ack", 32'(m0_ack_o), 32'h1);
        check("t2_m1_noack", 32'(m1_ack_o), 32'h0);
        step();
        ram_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        #1;
        check("t2_hold_m0", 32'(grant_o), 32'h1);
        step();
        check("t2_dead1", 32'(grant_o), 32'h0);
        step();
        check("t2_then_m1", 32'(grant_o), 32'h2);
        ram_ack_i = 1;
        #1;
        check("t2_m1_ack", 32'(m1_ack_o), 32'h1);
        check("t2_m0_noack", 32'(m0_ack_o), 32'h0);
        step();
        ram_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0; m0_cyc_i = 1; m0_stb_i = 1;
        step();
        check("t2_dead2", 32'(grant_o), 32'h0);
        m1_cyc_i = 1; m1_stb_i = 1;
        step();
        check("t2_rr_m0", 32'(grant_o), 32'h1);
        idle_inputs();
        step();
        step();

        // locked burst by master 1
        pulse_reset();
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_dat_i = 32'hA5A50001;
        m1_addr_i = 10'h3FF; m1_sel_i = 4'h3;
        step();
        check("t3_grant", 32'(grant_o), 32'h2);
        check("t3_we", 32'(ram_we_o), 32'h1);
        check("t3_dat", ram_dat_o, 32'hA5A50001);
        check("t3_addr", 32'(ram_addr_o), 32'h3FF);
        check("t3_sel", 32'(ram_sel_o), 32'h3);
        m0_cyc_i = 1; m0_stb_i = 1;
        for (int i = 0; i < 4; i++) begin
            ram_ack_i = 1;
            #1;
            check("t3_burst_m1_ack", 32'(m1_ack_o), 32'h1);
            check("t3_burst_m0_ack", 32'(m0_ack_o), 32'h0);
            check("t3_burst_grant", 32'(grant_o), 32'h2);
            step();
        end
        ram_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0;
        #1;
        check("t3_drop_n", 32'(grant_o), 32'h2);
        step();
        check("t3_dead", 32'(grant_o), 32'h0);
        step();
        check("t3_m0_n2", 32'(grant_o), 32'h1);
        idle_inputs();
        step();
        step();

        // watchdog abort
        pulse_reset();
        m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 10'h055;
        step();
        m1_cyc_i = 1; m1_stb_i = 1;
        #1;
        check("t4_grant", 32'(grant_o), 32'h1);
        check("t4_err_s", 32'(m0_err_o), 32'h0);
        for (int k = 1; k < TIMEOUT; k++) begin
            step();
            check("t4_err_early", 32'(m0_err_o), 32'h0);
        end
        step();
        ram_ack_i = 1;
        #1;
        check("t4_err", 32'(m0_err_o), 32'h1);
        check("t4_cyc_drop", 32'(ram_cyc_o), 32'h0);
        check("t4_stb_drop", 32'(ram_stb_o), 32'h0);
        check("t4_ack_ignored", 32'(m0_ack_o), 32'h0);
        check("t4_m1_err", 32'(m1_err_o), 32'h0);
        step();
        ram_ack_i = 0;
        #1;
        check("t4_err_pulse", 32'(m0_err_o), 32'h0);
        check("t4_idle", 32'(grant_o), 32'h0);
        check("t4_flag", 32'(timeout_flag_o), 32'h1);
        step();
        check("t4_m1_next", 32'(grant_o), 32'h2);
        check("t4_flag_hold", 32'(timeout_flag_o), 32'h1);
        timeout_clr_i = 1; m0_cyc_i = 0; m0_stb_i = 0;
        step();
        timeout_clr_i = 0;
        check("t4_flag_clr", 32'(timeout_flag_o), 32'h0);
        idle_inputs();
        step();
        step();

        // async reset mid master 1 write
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_dat_i = 32'h0BADF00D; m1_addr_i = 10'h100;
        step();
        check("t5_grant", 32'(grant_o), 32'h2);
        check("t5_we", 32'(ram_we_o), 32'h1);
        ram_dat_i = 32'h12345678;
        reset = 1'b1;
        #1;
        check("t5_rst_cyc", 32'(ram_cyc_o), 32'h0);
        check("t5_rst_we", 32'(ram_we_o), 32'h0);
        check("t5_rst_grant", 32'(grant_o), 32'h0);
        check("t5_rst_dat", m1_dat_o, 32'h12345678);
        reset = 1'b0;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0;
        ram_ack_i = 1;
        #1;
        check("t5_stray_m0", 32'(m0_ack_o), 32'h0);
        check("t5_stray_m1", 32'(m1_ack_o), 32'h0);
        step();
        check("t5_stay_idle", 32'(grant_o), 32'h0);
        ram_ack_i = 0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spell_rambus_arbiter.md
# spell_rambus_arbiter

Two-master Wishbone arbiter that shares the single OpenRAM port (`rambus_wb_*`) between the spell core's memory unit (master 0) and the host-side debug/loader path (master 1). It sits between `spell_mem`'s `sram_*` bus, the host loader and the top-level `rambus_wb_*` pins. Arbitration is round-robin and locked for the whole `cyc` of the winner. A timeout watchdog aborts transfers the RAM never acknowledges.

## Interface
- `ADDR_W`, default 10: RAM word-address width.
- `TIMEOUT`, default 255: number of stb-without-ack cycles before an abort; 0 disables the watchdog.
- `clock` in 1: system clock; the RAM runs on the same clock.
- `reset` in 1: asynchronous, active-high.
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i` in 1 each: master 0 (spell core) cycle, strobe and write enable.
- `m0_sel_i` in 4, `m0_dat_i` in 32, `m0_addr_i` in ADDR_W: master 0 byte select, write data and address.
- `m0_ack_o` out 1, `m0_err_o` out 1, `m0_dat_o` out 32: master 0 ack, abort and read data.
- `m1_*`: same set of signals as `m0_*`, for master 1 (host loader).
- `ram_cyc_o`, `ram_stb_o`, `ram_we_o` out 1 each; `ram_sel_o` out 4; `ram_dat_o` out 32; `ram_addr_o` out ADDR_W: the shared RAM bus.
- `ram_ack_i` in 1, `ram_dat_i` in 32: shared RAM bus ack and read data.
- `grant_o` out 2: one-hot current owner; 00 means idle.
- `timeout_flag_o` out 1: sticky abort indicator.
- `timeout_clr_i` in 1: clears `timeout_flag_o`.

## Operation
- States:
  - IDLE: no owner.
  - GRANT0: master 0 owns the bus.
  - GRANT1: master 1 owns the bus.
- IDLE arbitration:
  - If only one master has `cyc` high, that master is granted.
  - If both have `cyc` high, the master not in `last_grant` wins.
  - `last_grant` resets to 1, so master 0 wins the first contest.
- While in GRANTn:
  - Master n's stb/we/sel/dat/addr drive `ram_*` combinationally.
  - `ram_cyc_o` is 1.
  - `ram_ack_i` routes to `mn_ack_o` only; the other master's ack/err stay 0.
  - `ram_dat_i` fans out to both `m*_dat_o`; the value is valid only when qualified by ack.
- Lock: the owner keeps the bus while its `cyc` is high. Multiple strobes inside one `cyc` complete without re-arbitration.
- Release: owner `cyc` low → IDLE next cycle, and `last_grant` is set to n.
- Watchdog:
  - Counter clears on every ack, on entry to GRANTn, and whenever the owner's `stb` is low.
  - Counter increments each cycle the owner's `stb` is high and `ram_ack_i` is low.
  - When the count reaches TIMEOUT:
    - `mn_err_o` pulses for 1 cycle.
    - `ram_cyc_o`/`ram_stb_o` drop that same cycle.
    - State goes to IDLE, `last_grant` is set to n, and `timeout_flag_o` is set.
  - After an abort the master must drop `cyc`. Until it does, it is not re-granted and the other master may be.
- `ram_ack_i` arriving in IDLE, or on the cycle of an abort, is ignored.
- `timeout_clr_i` clears the flag; if a new timeout fires in the same cycle, set wins.
- `reset` asserted mid-transfer:
  - All outputs go to 0 immediately: `ram_*`, ack, err, `grant_o`, `timeout_flag_o`.
  - `m*_dat_o` follows `ram_dat_i`.
  - State goes to IDLE, `last_grant` to 1, counter to 0.
- Reset values: every output is 0.

## Timing
- Grant latency: request seen at cycle N (IDLE) → `grant_o` and `ram_cyc_o` high at N+1.
- Ack path: `ram_ack_i` → `mn_ack_o` is combinational, with zero added latency.
- Handover: owner drops `cyc` at N → IDLE at N+1 → other master granted at N+2, giving 1 dead bus cycle.
- Abort: stb high from cycle S with no ack → `mn_err_o` high at cycle S+TIMEOUT.
- Registered: state, `grant_o`, `last_grant`, watchdog counter, `timeout_flag_o`.
- Combinational: the `ram_*` mux and the ack/err routing.

## Structure
- Shared package `spell_pkg`:
  - Arbiter state enum (IDLE/GRANT0/GRANT1).
  - Grant one-hot constants.
  - Default `RAM_ADDR_W` = 10.
- One sub-module: `spell_bus_watchdog`, a parameterised TIMEOUT counter with `clear`, `enable` and `expired` signals.
- The remaining logic is the FSM plus the output mux.

## Test plan
- Single master, RAM acks the next cycle: master 0 reads address 0x012 → `ram_cyc_o` high 1 cycle after the request; `m0_ack_o` and `m0_dat_o` = `ram_dat_i` (0xDEADBEEF) the same cycle as `ram_ack_i`; `m1_ack_o` stays 0.
- Simultaneous requests directly after reset, then again after the first release: master 0 is granted first, then master 1, then master 0 on the next contest; exactly 1 idle cycle at each handover.
- Locked burst: master 1 holds `cyc` for 4 strobes while master 0 requests → all 4 acks go to master 1; master 0 is granted 2 cycles after master 1 drops `cyc`.
- Timeout with TIMEOUT=8: master 0 strobes and the RAM never acks → `m0_err_o` pulses at cycle 8; `ram_cyc_o` drops; `timeout_flag_o` = 1; a pending master 1 is granted next. `timeout_clr_i` then clears the flag.
- Async reset in the middle of a master 1 write: `ram_cyc_o`, `ram_we_o` and `grant_o` fall to 0 without a clock edge. After reset, a stray `ram_ack_i` produces no `m*_ack_o`.
